// File: rtl/fixed_point_activation_pipe_if.sv
// ---------------------------------------------------------------------------
// fixed_point_activation_pipe_if
//
// Purpose: bundles the valid/ready input and output streams of the
// fixed-point activation pipeline.
//
// Signals:
//   in_valid   upstream -> pipe   input transaction present
//   in_ready   pipe -> upstream   pipe accepts input this cycle
//   in_data    upstream -> pipe   signed fixed-point operand x
//   in_mode    upstream -> pipe   00 bypass, 01 sigmoid, 10 tanh, 11 ReLU
//   out_valid  pipe -> downstream result present
//   out_ready  downstream -> pipe downstream accepts result
//   out_data   pipe -> downstream signed fixed-point result
//
// Modports:
//   slave   the pipeline's view
//   master  the view of whoever drives operands and consumes results
// ---------------------------------------------------------------------------
interface fixed_point_activation_pipe_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [1:0]            in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fixed_point_activation_pipe.sv
// ---------------------------------------------------------------------------
// fixed_point_activation_pipe
//
// Purpose: three-stage pipelined fixed-point activation unit. Each operand
// carries its own function select (bypass, sigmoid, tanh, ReLU). Sigmoid is
// a four-segment piecewise-linear approximation evaluated on |u|; tanh is
// derived as 2*sigmoid(2x) - 1.
//
//   S1: tanh pre-scale (2x, saturated), sign capture and saturated |u|
//   S2: piecewise-linear segment evaluation p(|u|)
//   S3: sign fold, tanh post-scale and output select (drives out_data)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stream interface (slave modport): in_valid/in_ready/in_data/
//          in_mode and out_valid/out_ready/out_data
//   busy   high while any stage holds a valid transaction
//
// Flow control: every stage advances together when the output register is
// empty or being drained; otherwise the whole pipe holds. Bubbles are kept
// in place rather than collapsed.
// ---------------------------------------------------------------------------
module fixed_point_activation_pipe #(
    parameter int DATA_WIDTH = 12,
    parameter int INTEGER    = 6,
    parameter int FRACTION   = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fixed_point_activation_pipe_if.slave  bus,
    output logic                          busy
);

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'b00,
        MODE_SIGMOID = 2'b01,
        MODE_TANH    = 2'b10,
        MODE_RELU    = 2'b11
    } mode_t;

    // Two guard bits: enough headroom for 2x before saturation and for the
    // tanh post-scale 2s - 1.0, so nothing inside the pipe ever wraps.
    localparam int W = DATA_WIDTH + 2;

    localparam longint ONE_L = longint'(1) << FRACTION;
    localparam longint MAX_L = (longint'(1) << (DATA_WIDTH - 1)) - 1;
    localparam longint MIN_L = -(longint'(1) << (DATA_WIDTH - 1));

    localparam logic signed [W-1:0] ONE      = W'(ONE_L);
    localparam logic signed [W-1:0] HALF     = W'(ONE_L / 2);
    localparam logic signed [W-1:0] C_0625   = W'((ONE_L * 5) / 8);
    localparam logic signed [W-1:0] C_084375 = W'((ONE_L * 27) / 32);
    localparam logic signed [W-1:0] T_2375   = W'((ONE_L * 19) / 8);
    localparam logic signed [W-1:0] T_5      = W'(ONE_L * 5);
    localparam logic signed [W-1:0] MAX_V    = W'(MAX_L);
    localparam logic signed [W-1:0] MIN_V    = W'(MIN_L);

    generate
        if ((DATA_WIDTH != INTEGER + FRACTION) || (INTEGER < 4) || (FRACTION < 5)) begin : g_bad_params
            $error("fixed_point_activation_pipe: illegal DATA_WIDTH/INTEGER/FRACTION combination");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------------
    logic                   s1_valid_reg;
    mode_t                  s1_mode_reg;
    logic [DATA_WIDTH-1:0]  s1_x_reg;
    logic                   s1_neg_reg;
    logic signed [W-1:0]    s1_mag_reg;

    logic                   s2_valid_reg;
    mode_t                  s2_mode_reg;
    logic [DATA_WIDTH-1:0]  s2_x_reg;
    logic                   s2_neg_reg;
    logic signed [W-1:0]    s2_p_reg;

    logic                   s3_valid_reg;
    logic [DATA_WIDTH-1:0]  out_data_reg;

    logic advance;

    assign advance      = !s3_valid_reg || bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out_valid = s3_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign busy          = s1_valid_reg || s2_valid_reg || s3_valid_reg;

    // ---------------------------------------------------------------------
    // S1 combinational: u = sat(2x) for tanh else x; mag = sat(|u|)
    // ---------------------------------------------------------------------
    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] dbl;
    logic signed [W-1:0] u;
    logic signed [W-1:0] neg_u;
    logic signed [W-1:0] mag_next;
    logic                neg_next;

    always_comb begin
        x_ext = {{2{bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
        dbl   = x_ext <<< 1;
        u     = x_ext;
        if (mode_t'(bus.in_mode) == MODE_TANH) begin
            if (dbl > MAX_V) begin
                u = MAX_V;
            end else if (dbl < MIN_V) begin
                u = MIN_V;
            end else begin
                u = dbl;
            end
        end
        neg_next = u[W-1];
        neg_u    = -u;
        mag_next = u;
        if (neg_next) begin
            // Only the most-negative word has a magnitude beyond MAX_V.
            mag_next = (neg_u > MAX_V) ? MAX_V : neg_u;
        end
    end

    // ---------------------------------------------------------------------
    // S2 combinational: sigmoid magnitude p(m), segments picked high to low
    // ---------------------------------------------------------------------
    logic signed [W-1:0] p_next;

    always_comb begin
        if (s1_mag_reg >= T_5) begin
            p_next = ONE;
        end else if (s1_mag_reg >= T_2375) begin
            p_next = (s1_mag_reg >>> 5) + C_084375;
        end else if (s1_mag_reg >= ONE) begin
            p_next = (s1_mag_reg >>> 3) + C_0625;
        end else begin
            p_next = (s1_mag_reg >>> 2) + HALF;
        end
    end

    // ---------------------------------------------------------------------
    // S3 combinational: sign fold, tanh post-scale, output select
    // ---------------------------------------------------------------------
    logic signed [W-1:0]   s_fold;
    logic signed [W-1:0]   x2_ext;
    logic signed [W-1:0]   res;
    logic [DATA_WIDTH-1:0] out_next;

    always_comb begin
        s_fold = s2_neg_reg ? (ONE - s2_p_reg) : s2_p_reg;
        x2_ext = {{2{s2_x_reg[DATA_WIDTH-1]}}, s2_x_reg};
        case (s2_mode_reg)
            MODE_SIGMOID: res = s_fold;
            MODE_TANH:    res = (s_fold <<< 1) - ONE;
            MODE_RELU:    res = s2_x_reg[DATA_WIDTH-1] ? '0 : x2_ext;
            default:      res = x2_ext;
        endcase
        // Every selected result lies inside the DATA_WIDTH range.
        out_next = DATA_WIDTH'(res);
    end

    // ---------------------------------------------------------------------
    // Stage registers: all stages move together on advance
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= MODE_BYPASS;
            s1_x_reg     <= '0;
            s1_neg_reg   <= 1'b0;
            s1_mag_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_mode_reg  <= MODE_BYPASS;
            s2_x_reg     <= '0;
            s2_neg_reg   <= 1'b0;
            s2_p_reg     <= '0;
            s3_valid_reg <= 1'b0;
            out_data_reg <= '0;
        end else if (advance) begin
            s1_valid_reg <= bus.in_valid;
            s1_mode_reg  <= mode_t'(bus.in_mode);
            s1_x_reg     <= bus.in_data;
            s1_neg_reg   <= neg_next;
            s1_mag_reg   <= mag_next;

            s2_valid_reg <= s1_valid_reg;
            s2_mode_reg  <= s1_mode_reg;
            s2_x_reg     <= s1_x_reg;
            s2_neg_reg   <= s1_neg_reg;
            s2_p_reg     <= p_next;

            s3_valid_reg <= s2_valid_reg;
            out_data_reg <= out_next;
        end
    end

endmodule
